// File: rtl/evp_rd_addr_s_gen_if.sv
// EVP S-memory read-address generator handshake/bus bundle.
// Ports: start/base_addr/degree/stall requests in; ready/busy,
// S read address/enable, coeff_valid/coeff_last, done/err out.
interface evp_rd_addr_s_gen_if #(
    parameter int AW    = 7,
    parameter int DEG_W = 4
);
    logic             start;
    logic [AW-1:0]    base_addr;
    logic [DEG_W-1:0] degree;
    logic             stall;
    logic             ready;
    logic             busy;
    logic [AW-1:0]    rd_addr_S_EVP;
    logic             rd_en_S_EVP;
    logic             coeff_valid;
    logic             coeff_last;
    logic             done;
    logic             err;

    modport master (
        output start, base_addr, degree, stall,
        input  ready, busy, rd_addr_S_EVP, rd_en_S_EVP,
        input  coeff_valid, coeff_last, done, err
    );

    modport slave (
        input  start, base_addr, degree, stall,
        output ready, busy, rd_addr_S_EVP, rd_en_S_EVP,
        output coeff_valid, coeff_last, done, err
    );
endinterface

// File: rtl/evp_rd_addr_s_gen.sv
// EVP S-memory read-address generator: Horner-order coefficient fetch.
// Ports: clk, rst (async high), bus (slave modport of the _if bundle).
// Macro EVP_RD_LAT2_EN selects a 2-cycle S read latency (default 1).
module evp_rd_addr_s_gen #(
    parameter int s_size  = 88,
    parameter int max_deg = 10,
    parameter int deg_w   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    evp_rd_addr_s_gen_if.slave    bus
);
    localparam int AW = $clog2(s_size);
`ifdef EVP_RD_LAT2_EN
    localparam int L = 2;
`else
    localparam int L = 1;
`endif

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    cur_q, cur_d;
    logic [deg_w-1:0] rem_q, rem_d;
    logic             seen_q, seen_d;
    logic             err_q, err_d;
    logic [L-1:0]     vld_q, lst_q;

    logic             rd_en;
    logic             rd_last;
    logic             done_c;
    logic             req_bad;
    logic [AW:0]      top_addr;

    // One extra bit so an out-of-range top address cannot wrap.
    assign top_addr = {1'b0, bus.base_addr} + (AW+1)'(bus.degree);
    assign req_bad  = (bus.degree > deg_w'(max_deg))
                   || (top_addr > (AW+1)'(s_size - 1));

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        rem_d   = rem_q;
        seen_d  = seen_q;
        err_d   = 1'b0;
        rd_en   = 1'b0;
        rd_last = 1'b0;
        done_c  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (req_bad) begin
                        err_d = 1'b1;
                    end else begin
                        cur_d   = top_addr[AW-1:0];
                        rem_d   = bus.degree;
                        seen_d  = 1'b0;
                        state_d = READ;
                    end
                end
            end
            READ: begin
                if (!bus.stall) begin
                    rd_en = 1'b1;
                    if (rem_q == '0) begin
                        rd_last = 1'b1;
                        state_d = DRAIN;
                    end else begin
                        cur_d = cur_q - AW'(1);
                        rem_d = rem_q - deg_w'(1);
                    end
                end
            end
            DRAIN: begin
                // done fires the cycle after the last beat is seen.
                if (seen_q) begin
                    done_c  = 1'b1;
                    seen_d  = 1'b0;
                    state_d = IDLE;
                end else if (bus.coeff_valid && bus.coeff_last) begin
                    seen_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cur_q   <= '0;
            rem_q   <= '0;
            seen_q  <= 1'b0;
            err_q   <= 1'b0;
            vld_q   <= '0;
            lst_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            rem_q   <= rem_d;
            seen_q  <= seen_d;
            err_q   <= err_d;
`ifdef EVP_RD_LAT2_EN
            vld_q   <= {vld_q[0], rd_en};
            lst_q   <= {lst_q[0], rd_last};
`else
            vld_q   <= rd_en;
            lst_q   <= rd_last;
`endif
        end
    end

    // cur_q only moves while reading, so it also holds the last address.
    assign bus.rd_addr_S_EVP = cur_q;
    assign bus.rd_en_S_EVP   = rd_en;
    assign bus.coeff_valid   = vld_q[L-1];
    assign bus.coeff_last    = vld_q[L-1] & lst_q[L-1];
    assign bus.ready         = (state_q == IDLE);
    assign bus.busy          = (state_q != IDLE);
    assign bus.done          = done_c;
    assign bus.err           = err_q;
endmodule
